// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matmul_nxn block:
//   state_t : controller states (IDLE, COMPUTE, OUTPUT)
//   idx_w   : width of a row-major element index for an n x n matrix
//   cnt_w   : width of a row/column/inner-product counter (0..n-1)
//   acc_w   : accumulator width that cannot overflow over n products
// ---------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // n products of two dw-bit unsigned values stay below 2^(2*dw + clog2(n)).
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_nxn_mac.sv
// ---------------------------------------------------------------------------
// matmul_mac
// Registered unsigned multiply-accumulate.
//   clk, rst_n : clock, synchronous active-low reset (clears the accumulator)
//   en_i       : perform one MAC this cycle
//   clr_i      : with en_i, start a new sum from this product instead of
//                adding to the previous one
//   a_i, b_i   : DW-bit unsigned operands
//   acc_o      : AW-bit accumulated sum (registered)
// ---------------------------------------------------------------------------
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = acc_w(8, 3)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [AW-1:0] acc_o
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_d;
    logic [AW-1:0]   acc_q;

    always_comb begin
        prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        acc_d = acc_q;
        if (en_i) begin
            acc_d = clr_i ? AW'(prod) : acc_q + AW'(prod);
        end
    end

    // ---- stage p1: accumulator register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_nxn.sv
// ---------------------------------------------------------------------------
// matmul_nxn
// Computes C = A x B for N x N unsigned matrices with a single MAC, then
// streams C out in row-major order over a valid/ready handshake.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   a_wr, a_loc, a_val      : write A[a_loc] (row-major), honoured in IDLE only
//   b_wr, b_loc, b_val      : write B[b_loc] (row-major), honoured in IDLE only
//   start                   : begin a run (IDLE only)
//   busy                    : high while computing or streaming results
//   res_valid/res_ready     : result handshake
//   res_data, res_loc       : result value and its row-major index
//   done                    : one-cycle pulse after the last result transfer
//
// Build option
//   MATMUL_SAT_EN : when defined, results above 2^RW-1 clamp to 2^RW-1;
//                   otherwise the low RW bits of the sum are kept.
// ---------------------------------------------------------------------------
module matmul_nxn
    import matmul_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int RW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_wr,
    input  logic [idx_w(N)-1:0]  a_loc,
    input  logic [DW-1:0]        a_val,
    input  logic                 b_wr,
    input  logic [idx_w(N)-1:0]  b_loc,
    input  logic [DW-1:0]        b_val,
    input  logic                 start,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RW-1:0]        res_data,
    output logic [idx_w(N)-1:0]  res_loc,
    output logic                 done
);

    localparam int LW = idx_w(N);
    localparam int KW = cnt_w(N);
    localparam int AW = acc_w(DW, N);
    localparam int NN = N * N;

    localparam logic [KW-1:0] NM1    = KW'(N - 1);
    localparam logic [LW-1:0] N_L    = LW'(N);
    localparam logic [LW-1:0] LAST_L = LW'(NN - 1);
    localparam logic [LW:0]   NN_L   = (LW + 1)'(NN);

    function automatic logic [RW-1:0] sat_acc(input logic [AW-1:0] acc);
`ifdef MATMUL_SAT_EN
        if (|(acc >> RW)) begin
            return '1;
        end
        return RW'(acc);
`else
        return RW'(acc);
`endif
    endfunction

    state_t state_q, state_d;

    logic [DW-1:0] a_q   [NN];
    logic [DW-1:0] b_q   [NN];
    logic [RW-1:0] res_q [NN];

    logic [KW-1:0] i_q, j_q, k_q;
    logic [LW-1:0] out_idx_q;
    logic          done_q;

    logic          vld_p1_q;
    logic [LW-1:0] wb_idx_p1_q;

    logic          in_idle, in_compute, mac_last, k_last, hs, out_last;
    logic          a_wr_ok, b_wr_ok;
    logic [LW-1:0] a_idx, b_idx, c_idx;
    logic [AW-1:0] acc;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_compute = (state_q == ST_COMPUTE);
    assign k_last     = (k_q == NM1);
    assign mac_last   = in_compute && (i_q == NM1) && (j_q == NM1) && k_last;
    assign hs         = res_valid && res_ready;
    assign out_last   = (out_idx_q == LAST_L);

    assign a_wr_ok = in_idle && a_wr && ({1'b0, a_loc} < NN_L);
    assign b_wr_ok = in_idle && b_wr && ({1'b0, b_loc} < NN_L);

    // Loop order i, j, k: A[i][k] * B[k][j] accumulates into C[i][j].
    assign a_idx = LW'(i_q) * N_L + LW'(k_q);
    assign b_idx = LW'(k_q) * N_L + LW'(j_q);
    assign c_idx = LW'(i_q) * N_L + LW'(j_q);

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (mac_last) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready && out_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand storage; a same-cycle write and start lands before COMPUTE reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
            end
        end else begin
            if (a_wr_ok) begin
                a_q[a_loc] <= a_val;
            end
            if (b_wr_ok) begin
                b_q[b_loc] <= b_val;
            end
        end
    end

    // ---- stage p0: loop counters and operand fetch ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (in_compute) begin
            if (!k_last) begin
                k_q <= k_q + 1'b1;
            end else begin
                k_q <= '0;
                if (j_q != NM1) begin
                    j_q <= j_q + 1'b1;
                end else begin
                    j_q <= '0;
                    i_q <= (i_q == NM1) ? '0 : i_q + 1'b1;
                end
            end
        end
    end

    matmul_mac #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (in_compute),
        .clr_i (k_q == '0),
        .a_i   (a_q[a_idx]),
        .b_i   (b_q[b_idx]),
        .acc_o (acc)
    );

    // ---- stage p1: finished sum is in the accumulator; write it back ----
    // The final write-back happens in the first OUTPUT cycle, long before the
    // stream reaches that last index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            wb_idx_p1_q <= '0;
        end else begin
            vld_p1_q    <= in_compute && k_last;
            wb_idx_p1_q <= c_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NN; n++) begin
                res_q[n] <= '0;
            end
        end else if (vld_p1_q) begin
            res_q[wb_idx_p1_q] <= sat_acc(acc);
        end
    end

    // ---- result stream ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= hs && out_last;
            if (hs) begin
                out_idx_q <= out_last ? '0 : out_idx_q + 1'b1;
            end
        end
    end

    assign res_data = res_q[out_idx_q];
    assign res_loc  = out_idx_q;
    assign done     = done_q;

endmodule

// File: doc/matmul_nxn.md
MATMUL_NXN -- requirements
Module: matmul_nxn

Interface
REQ-001 SHALL have parameter N, default 3: matrix dimension (N x N), legal 2..16.
REQ-002 SHALL have parameter DW, default 8: element width, unsigned.
REQ-003 SHALL have parameter RW, default 8: result width.
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have ports a_wr, a_loc, a_val  input  1 / clog2(N*N) / DW: matrix A element write, row-major index.
REQ-007 SHALL have ports b_wr, b_loc, b_val  input  1 / clog2(N*N) / DW: matrix B element write, row-major index.
REQ-008 SHALL have port start  input  1: begin C = A x B.
REQ-009 SHALL have port busy  output  1: high in COMPUTE and OUTPUT.
REQ-010 SHALL have ports res_valid (output 1), res_ready (input 1), res_data (output RW): result stream.
REQ-011 SHALL have ports res_loc  output  clog2(N*N): row-major index of res_data.
REQ-012 SHALL have port done  output  1: one-cycle pulse after the last result is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, COMPUTE, OUTPUT; IDLE->COMPUTE on start; COMPUTE->OUTPUT after N^3 cycles; OUTPUT->IDLE on N*N-th handshake.
REQ-014 SHALL accept A/B writes only in IDLE; writes in other states, or with loc >= N*N, SHALL be ignored.
REQ-015 SHALL retain A and B after a run, so start can be reissued without reloading.
REQ-016 SHALL, for a write and start in the same IDLE cycle, store the write before compute uses it.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL compute with one multiply-accumulate per cycle, order i (row), j (col), k innermost, in COMPUTE for exactly N^3 cycles.
REQ-019 SHALL accumulate at full width 2*DW+clog2(N) with no internal overflow.
REQ-020 SHALL store each finished C[i][j] in an N*N result buffer of RW-bit entries.
REQ-021 SHALL assert res_valid in the first OUTPUT cycle, presenting C in row-major order; transfer occurs when res_valid && res_ready.
REQ-022 SHALL hold res_data and res_loc stable while res_valid && !res_ready.
REQ-023 SHALL pulse done in the cycle after the final handshake, with busy low in that same cycle.

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, go to IDLE and clear A, B, results and accumulator to 0; busy, res_valid, done and res_loc SHALL be 0.
REQ-025 SHALL abort any COMPUTE or OUTPUT on reset with no done pulse.

Configuration
REQ-026 SHALL, with macro MATMUL_SAT_EN defined, clamp each accumulator value exceeding 2^RW-1 to 2^RW-1 when stored.
REQ-027 SHALL, without MATMUL_SAT_EN, store the low RW bits of the accumulator (wrap).

Structure
REQ-028 SHALL place the FSM state enum and index-width helper (clog2-based) in package matmul_pkg.
REQ-029 SHALL use sub-module matmul_mac (registered multiply-accumulate with clear) for the datapath.

Verification
REQ-030 N=3: A[k]=k, B[k]=k, k=0..8, start, res_ready=1 -> 15,18,21,42,54,66,69,90,111 at res_loc 0..8; first res_valid N^3=27 cycles after start; done after 9th.
REQ-031 N=3, all A=B=255 -> every result 255 with MATMUL_SAT_EN; 3 (195075 mod 256) without.
REQ-032 res_ready toggled 1-0-1 each cycle -> same 9 values in order, no loss or duplicates, outputs stable while stalled.
REQ-033 a_wr with a_loc=5, a_val=99 during COMPUTE, then rerun with start -> identical results to the prior run (write ignored).
REQ-034 rst_n low for 1 cycle mid-COMPUTE -> busy=0, no done; the next run with zero matrices yields all-zero results.
REQ-035 Second start pulsed during OUTPUT -> ignored; exactly one done per accepted start.
